// File: rtl/pio_pkg.sv
// Shared definitions for the pio configuration sequencer: action codes,
// field widths and the sequencer state encoding.
package pio_pkg;
    localparam int ACTION_W = 6;
    localparam int INDEX_W  = 5;
    localparam int MINDEX_W = 2;

    localparam logic [ACTION_W-1:0] ACT_NONE  = 6'd0;
    localparam logic [ACTION_W-1:0] ACT_INSTR = 6'd1;
    localparam logic [ACTION_W-1:0] ACT_PEND  = 6'd2;
    localparam logic [ACTION_W-1:0] ACT_PULL  = 6'd3;
    localparam logic [ACTION_W-1:0] ACT_PUSH  = 6'd4;
    localparam logic [ACTION_W-1:0] ACT_GRPS  = 6'd5;
    localparam logic [ACTION_W-1:0] ACT_EN    = 6'd6;
    localparam logic [ACTION_W-1:0] ACT_DIV   = 6'd7;
    localparam logic [ACTION_W-1:0] ACT_SIDES = 6'd8;
    localparam logic [ACTION_W-1:0] ACT_IMM   = 6'd9;
    localparam logic [ACTION_W-1:0] ACT_SHIFT = 6'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_INSTR,
        ST_SMCFG,
        ST_ENABLE,
        ST_FIN
    } seq_state_e;
endpackage

// File: rtl/pio_sm_picker.sv
// Finds the lowest set bit of mask strictly above cur (or from bit 0 when
// first is set); none flags that no machine is left.
module pio_sm_picker
    import pio_pkg::*;
#(
    parameter int NUM_SM = 4
) (
    input  logic [NUM_SM-1:0]   mask,
    input  logic [MINDEX_W-1:0] cur,
    input  logic                first,
    output logic [MINDEX_W-1:0] nxt,
    output logic                none
);
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        // Descending scan so the lowest qualifying bit is the last one written.
        for (int i = NUM_SM - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt  = MINDEX_W'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/pio_cfg_sequencer.sv
// Loads a program and per-machine configuration into the pio after a start
// pulse, and forwards host actions to the pio while idle.
module pio_cfg_sequencer
    import pio_pkg::*;
#(
    parameter int NUM_SM  = 4,
    parameter int IMEM_AW = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [5:0]             plen,
    input  logic [NUM_SM-1:0]      sm_mask,
    input  logic [32*NUM_SM-1:0]   cfg_pend,
    input  logic [24*NUM_SM-1:0]   cfg_div,
    input  logic [32*NUM_SM-1:0]   cfg_grps,
    input  logic [32*NUM_SM-1:0]   cfg_shift,
    output logic [IMEM_AW-1:0]     imem_addr,
    output logic                   imem_rd,
    input  logic [15:0]            imem_data,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [ACTION_W-1:0]    host_action,
    input  logic [INDEX_W-1:0]     host_index,
    input  logic [MINDEX_W-1:0]    host_mindex,
    input  logic [31:0]            host_din,
    output logic [ACTION_W-1:0]    action,
    output logic [INDEX_W-1:0]     index,
    output logic [MINDEX_W-1:0]    mindex,
    output logic [31:0]            din,
    output logic                   busy,
    output logic                   done
);
    localparam logic [5:0] PLEN_MAX = 6'(1 << IMEM_AW);

    seq_state_e            state_q, state_d;
    logic [ACTION_W-1:0]   action_q, action_d;
    logic [INDEX_W-1:0]    index_q, index_d;
    logic [MINDEX_W-1:0]   mindex_q, mindex_d;
    logic [31:0]           din_q, din_d;
    logic [IMEM_AW-1:0]    imem_addr_q, imem_addr_d;
    logic                  imem_rd_q, imem_rd_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [5:0]            plen_q, plen_d, icnt_q, icnt_d;
    logic [NUM_SM-1:0]     mask_q, mask_d;
    logic [MINDEX_W-1:0]   m_q, m_d;
    logic [1:0]            sub_q, sub_d;
    logic [MINDEX_W-1:0]   pick_idx;
    logic                  pick_none, cfg_go;
    logic [31:0]           pend_pick, word_next;
    logic [ACTION_W-1:0]   act_next;

    pio_sm_picker #(.NUM_SM(NUM_SM)) u_picker (
        .mask  (mask_q),
        .cur   (m_q),
        .first (state_q != ST_SMCFG),
        .nxt   (pick_idx),
        .none  (pick_none)
    );

    assign pend_pick = cfg_pend[32*pick_idx +: 32];

    always_comb begin
        word_next = cfg_shift[32*m_q +: 32];
        act_next  = ACT_SHIFT;
        case (sub_q)
            2'd0: begin word_next = {8'b0, cfg_div[24*m_q +: 24]}; act_next = ACT_DIV; end
            2'd1: begin word_next = cfg_grps[32*m_q +: 32];        act_next = ACT_GRPS; end
            default: ;
        endcase
    end

    assign host_ready = (state_q == ST_IDLE) && !start;

    always_comb begin
        state_d     = state_q;
        action_d    = ACT_NONE;
        index_d     = index_q;
        mindex_d    = mindex_q;
        din_d       = '0;
        imem_addr_d = imem_addr_q;
        imem_rd_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        plen_d      = plen_q;
        mask_d      = mask_q;
        icnt_d      = icnt_q;
        m_d         = m_q;
        sub_d       = sub_q;
        cfg_go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PREFETCH;
                    busy_d      = 1'b1;
                    plen_d      = (plen > PLEN_MAX) ? PLEN_MAX : plen;
                    mask_d      = sm_mask;
                    imem_addr_d = '0;
                    imem_rd_d   = (plen != 6'd0);
                end else if (host_valid) begin
                    action_d = host_action;
                    index_d  = host_index;
                    mindex_d = host_mindex;
                    din_d    = host_din;
                end
            end
            ST_PREFETCH: begin
                if (plen_q != 6'd0) begin
                    state_d  = ST_INSTR;
                    action_d = ACT_INSTR;
                    index_d  = '0;
                    icnt_d   = '0;
                    if (plen_q > 6'd1) begin
                        imem_rd_d   = 1'b1;
                        imem_addr_d = IMEM_AW'(1);
                    end
                end else begin
                    cfg_go = 1'b1;
                end
            end
            ST_INSTR: begin
                if (icnt_q + 6'd1 < plen_q) begin
                    icnt_d   = icnt_q + 6'd1;
                    action_d = ACT_INSTR;
                    index_d  = icnt_d[INDEX_W-1:0];
                    if (icnt_q + 6'd2 < plen_q) begin
                        imem_rd_d   = 1'b1;
                        imem_addr_d = IMEM_AW'(icnt_q + 6'd2);
                    end
                end else begin
                    cfg_go = 1'b1;
                end
            end
            ST_SMCFG: begin
                if (sub_q != 2'd3) begin
                    sub_d    = sub_q + 2'd1;
                    action_d = act_next;
                    din_d    = word_next;
                end else begin
                    cfg_go = 1'b1;
                end
            end
            ST_ENABLE: begin
                state_d = ST_FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Move on to the next selected machine, or to EN once none is left.
        if (cfg_go) begin
            if (!pick_none) begin
                state_d  = ST_SMCFG;
                m_d      = pick_idx;
                sub_d    = 2'd0;
                mindex_d = pick_idx;
                action_d = ACT_PEND;
                din_d    = pend_pick;
            end else begin
                state_d  = ST_ENABLE;
                action_d = ACT_EN;
                mindex_d = '0;
                din_d    = 32'(mask_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            action_q    <= ACT_NONE;
            index_q     <= '0;
            mindex_q    <= '0;
            din_q       <= '0;
            imem_addr_q <= '0;
            imem_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            plen_q      <= '0;
            mask_q      <= '0;
            icnt_q      <= '0;
            m_q         <= '0;
            sub_q       <= '0;
        end else begin
            state_q     <= state_d;
            action_q    <= action_d;
            index_q     <= index_d;
            mindex_q    <= mindex_d;
            din_q       <= din_d;
            imem_addr_q <= imem_addr_d;
            imem_rd_q   <= imem_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            plen_q      <= plen_d;
            mask_q      <= mask_d;
            icnt_q      <= icnt_d;
            m_q         <= m_d;
            sub_q       <= sub_d;
        end
    end

    assign action    = action_q;
    assign index     = index_q;
    assign mindex    = mindex_q;
    // The instruction memory output is itself a register, so its word is passed
    // straight through in the INSTR cycle it belongs to.
    assign din       = (state_q == ST_INSTR) ? {16'b0, imem_data} : din_q;
    assign imem_addr = imem_addr_q;
    assign imem_rd   = imem_rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_pio_cfg_sequencer.sv
// Randomized bench for pio_cfg_sequencer against a queue-based reference of
// the expected per-cycle pio action stream.
module tb_pio_cfg_sequencer;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   plen;
    logic [3:0]   sm_mask;
    logic [127:0] cfg_pend, cfg_grps, cfg_shift;
    logic [95:0]  cfg_div;
    logic [4:0]   imem_addr;
    logic         imem_rd;
    logic [15:0]  imem_data;
    logic         host_valid, host_ready;
    logic [5:0]   host_action;
    logic [4:0]   host_index;
    logic [1:0]   host_mindex;
    logic [31:0]  host_din;
    logic [5:0]   action;
    logic [4:0]   index;
    logic [1:0]   mindex;
    logic [31:0]  din;
    logic         busy, done;

    typedef struct {
        int          act;
        int          idx;
        int          mi;
        logic [31:0] d;
    } op_t;

    logic [15:0] mem [32];
    int rd_cnt, last_rd;
    int n_vec = 0, n_err = 0;

    pio_cfg_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .plen(plen), .sm_mask(sm_mask),
        .cfg_pend(cfg_pend), .cfg_div(cfg_div), .cfg_grps(cfg_grps), .cfg_shift(cfg_shift),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .host_valid(host_valid), .host_ready(host_ready), .host_action(host_action),
        .host_index(host_index), .host_mindex(host_mindex), .host_din(host_din),
        .action(action), .index(index), .mindex(mindex), .din(din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) begin
            imem_data <= mem[imem_addr];
            rd_cnt     = rd_cnt + 1;
            last_rd    = int'(imem_addr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired (got running, want finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg;
        for (int m = 0; m < 4; m++) begin
            cfg_pend[32*m +: 32]  = $urandom;
            cfg_div[24*m +: 24]   = 24'($urandom);
            cfg_grps[32*m +: 32]  = $urandom;
            cfg_shift[32*m +: 32] = $urandom;
        end
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    endtask

    // hmode: 0 no host traffic, 1 host request only alongside start, 2 PUSH held throughout
    task automatic run_seq(input int pl, input logic [3:0] mk, input int hmode);
        op_t q[$];
        op_t o;
        int  n;
        n = (pl > 32) ? 32 : pl;
        for (int i = 0; i < n; i++) begin
            o.act = 1; o.idx = i; o.mi = -1; o.d = {16'b0, mem[i]};
            q.push_back(o);
        end
        for (int m = 0; m < 4; m++) begin
            if (mk[m]) begin
                o.idx = -1; o.mi = m;
                o.act = 2;  o.d = cfg_pend[32*m +: 32];         q.push_back(o);
                o.act = 7;  o.d = {8'b0, cfg_div[24*m +: 24]};  q.push_back(o);
                o.act = 5;  o.d = cfg_grps[32*m +: 32];         q.push_back(o);
                o.act = 10; o.d = cfg_shift[32*m +: 32];        q.push_back(o);
            end
        end
        o.act = 6; o.idx = -1; o.mi = 0; o.d = {28'b0, mk};
        q.push_back(o);

        rd_cnt = 0; last_rd = -1;
        start = 1'b1; plen = 6'(pl); sm_mask = mk;
        host_valid = (hmode != 0); host_action = 6'd4; host_index = 5'd3;
        host_mindex = 2'd2; host_din = 32'd1;
        #1;
        chk("ready_at_start", host_ready, 0);
        step;
        start = 1'b0; plen = 6'($urandom); sm_mask = 4'($urandom);
        if (hmode == 1) host_valid = 1'b0;
        chk("c1_busy", busy, 1);
        chk("c1_action", action, 0);
        chk("c1_done", done, 0);
        foreach (q[k]) begin
            start = 1'($urandom_range(0, 1));
            step;
            chk("op_action", action, 64'(q[k].act));
            chk("op_din", din, q[k].d);
            if (q[k].idx >= 0) chk("op_index", index, 64'(q[k].idx));
            if (q[k].mi >= 0) chk("op_mindex", mindex, 64'(q[k].mi));
            chk("op_busy", busy, 1);
            chk("op_done", done, 0);
            if (hmode == 2) chk("busy_ready", host_ready, 0);
        end
        start = 1'b0;
        step;
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_action", action, 0);
        chk("fin_din", din, 0);
        chk("rd_count", 64'(rd_cnt), 64'(n));
        if (n > 0) begin
            chk("last_rd", 64'(last_rd), 64'(n - 1));
            chk("imem_addr_last", imem_addr, 64'(n - 1));
        end
        step;
        chk("post_done", done, 0);
        chk("post_action", action, 0);
        if (hmode == 2) begin
            for (int t = 0; t < 4 && !host_ready; t++) step;
            chk("ready_after", host_ready, 1);
            step;
            host_valid = 1'b0;
            chk("push_action", action, 4);
            chk("push_din", din, 1);
            chk("push_index", index, 3);
            step;
            chk("push_gap", action, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; plen = '0; sm_mask = '0;
        host_valid = 1'b0; host_action = '0; host_index = '0; host_mindex = '0; host_din = '0;
        cfg_pend = '0; cfg_div = '0; cfg_grps = '0; cfg_shift = '0;
        rd_cnt = 0; last_rd = -1;
        rand_cfg();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_action", action, 0);
        chk("rst_index", index, 0);
        chk("rst_mindex", mindex, 0);
        chk("rst_din", din, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_rd", imem_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        step;
        chk("idle_ready", host_ready, 1);

        // Directed program from the test plan
        mem[0] = 16'h6001; mem[1] = 16'hA0E1;
        cfg_pend[31:0] = 32'h0000_1000; cfg_div[23:0] = 24'h000100;
        cfg_grps[31:0] = 32'h0010_0000; cfg_shift[31:0] = 32'hA008_0000;
        run_seq(2, 4'b0001, 0);

        rand_cfg();
        run_seq(0, 4'b1010, 0);
        rand_cfg();
        run_seq(40, 4'($urandom), 0);
        rand_cfg();
        run_seq(32, 4'b0000, 0);

        // Host forwarding while idle
        for (int i = 0; i < 6; i++) begin
            logic [5:0] a; logic [4:0] ix; logic [1:0] mi; logic [31:0] d;
            a = 6'($urandom_range(1, 10)); ix = 5'($urandom); mi = 2'($urandom); d = $urandom;
            host_valid = 1'b1; host_action = a; host_index = ix; host_mindex = mi; host_din = d;
            #1;
            chk("host_ready", host_ready, 1);
            step;
            host_valid = 1'b0;
            chk("host_action", action, a);
            chk("host_index", index, ix);
            chk("host_mindex", mindex, mi);
            chk("host_din", din, d);
            step;
            chk("host_gap_action", action, 0);
            chk("host_gap_din", din, 0);
            chk("host_gap_index", index, ix);
        end

        rand_cfg();
        run_seq(3, 4'b0110, 1);
        rand_cfg();
        run_seq(4, 4'b1001, 2);

        // Reset during the third INSTR cycle, then a full replay
        rand_cfg();
        start = 1'b1; plen = 6'd5; sm_mask = 4'b0011;
        step;
        start = 1'b0;
        repeat (3) step;
        chk("pre_rst_action", action, 1);
        chk("pre_rst_index", index, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_action", action, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_din", din, 0);
        chk("mid_rst_imem_rd", imem_rd, 0);
        step;
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            step;
            chk("after_rst_done", done, 0);
            chk("after_rst_action", action, 0);
        end
        run_seq(5, 4'b0011, 0);

        for (int r = 0; r < 8; r++) begin
            rand_cfg();
            run_seq($urandom_range(0, 40), 4'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
